// File: rtl/ad100_pkg.sv
//==============================================================================
// Module      : ad100_pkg
// Description : Shared trace record type, sync byte and record byte count.
//               Record width depends on TRACE_REGS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ad100_pkg;

    localparam logic [7:0] TRACE_SYNC = 8'hA5;

`ifdef TRACE_REGS_EN
    localparam int TRACE_REC_BYTES = 17;

    typedef struct packed {
        logic [31:0] sp;
        logic [31:0] ra;
        logic [31:0] inst;
        logic [31:0] pc;
    } trace_rec_t;
`else
    localparam int TRACE_REC_BYTES = 9;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } trace_rec_t;
`endif

    localparam int TRACE_IDX_W = $clog2(TRACE_REC_BYTES);

    // Fields sit little-endian behind the sync byte, so byte N of the frame is
    // simply the Nth octet of {record, sync}.
    function automatic logic [7:0] trace_rec_byte(
        input trace_rec_t             rec,
        input logic [TRACE_IDX_W-1:0] idx
    );
        logic [TRACE_REC_BYTES*8-1:0] flat;
        flat = {rec, TRACE_SYNC};
        return flat[{idx, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
//==============================================================================
// Module      : uart_tx
// Description : 8N1 byte serialiser with ready/valid byte input; a new byte
//               may be accepted on the final clock of the stop bit.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last_clk = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic               r_txd,     w_txd_nxt;
    logic               w_tick;

    assign w_tick  = (r_clk_cnt == c_last_clk);
    assign o_ready = (r_state == S_IDLE) || ((r_state == S_STOP) && w_tick);
    assign o_txd   = r_txd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = w_tick ? '0 : r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_txd_nxt     = 1'b1;

        case (r_state)
            S_IDLE:  w_clk_cnt_nxt = '0;
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (i_valid && o_ready) begin
            w_state_nxt   = S_START;
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = i_data;
        end

        // Line level is registered from the next state so it changes on bit edges only.
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/trace_tx.sv
//==============================================================================
// Module      : trace_tx
// Description : Buffers retired-instruction records and streams them out as
//               UART frames. Define TRACE_REGS_EN to include ra/sp in records.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module trace_tx
    import ad100_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_inst,
    input  logic [31:0] retire_ra,
    input  logic [31:0] retire_sp,
    output logic        txd,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int                     c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [TRACE_IDX_W-1:0] c_last_idx = TRACE_IDX_W'(TRACE_REC_BYTES - 1);

    localparam logic R_IDLE = 1'b0;
    localparam logic R_SEND = 1'b1;

    trace_rec_t                 w_in;
    trace_rec_t                 w_head;
    trace_rec_t                 r_mem [FIFO_DEPTH];
    trace_rec_t                 r_rec;
    logic [c_aw:0]              r_wr_ptr, r_rd_ptr;
    logic                       w_full, w_empty, w_req, w_push, w_drop, w_pop;
    logic                       r_state, w_state_nxt;
    logic [TRACE_IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                       r_tail, w_tail_nxt;
    logic                       w_byte_valid, w_byte_ready;
    logic [7:0]                 w_byte;

`ifdef TRACE_REGS_EN
    assign w_in = '{sp: retire_sp, ra: retire_ra, inst: retire_inst, pc: retire_pc};
`else
    logic w_unused_regs;
    assign w_unused_regs = ^{retire_ra, retire_sp};
    assign w_in = '{inst: retire_inst, pc: retire_pc};
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_req   = retire_valid && enable;
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign w_push  = w_req && !w_full;
    assign w_drop  = w_req && w_full;
    assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= w_in;
        if (w_pop)  r_rec <= w_head;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // r_tail: every byte of the record is handed over, waiting for the last stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tail_nxt  = r_tail;
        w_pop       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = R_SEND;
                    w_idx_nxt   = '0;
                    w_tail_nxt  = 1'b0;
                end
            end
            R_SEND: begin
                if (!r_tail) begin
                    if (w_byte_ready) begin
                        if (r_idx == c_last_idx) begin
                            if (!w_empty) begin
                                w_pop     = 1'b1;
                                w_idx_nxt = '0;
                            end else begin
                                w_tail_nxt = 1'b1;
                            end
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end else if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_idx_nxt  = '0;
                    w_tail_nxt = 1'b0;
                end else if (w_byte_ready) begin
                    w_state_nxt = R_IDLE;
                    w_tail_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    assign w_byte_valid = (r_state == R_SEND) && !r_tail;
    assign w_byte       = trace_rec_byte(r_rec, r_idx);
    assign busy         = (r_state != R_IDLE) || !w_empty;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_byte_valid),
        .i_data  (w_byte),
        .o_ready (w_byte_ready),
        .o_txd   (txd)
    );

endmodule

`default_nettype wire

// File: doc/trace_tx.md
TRACE_TX -- requirements
Module: trace_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per UART bit (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, records buffered (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  capture enable.
REQ-006 SHALL have port retire_valid  input  1  one instruction retires this cycle.
REQ-007 SHALL have port retire_pc  input  32  byte address of the retired instruction.
REQ-008 SHALL have port retire_inst  input  32  retired instruction word.
REQ-009 SHALL have port retire_ra  input  32  x1 value after retirement.
REQ-010 SHALL have port retire_sp  input  32  x2 value after retirement.
REQ-011 SHALL have port txd  output  1  UART 8N1 serial out, idle high.
REQ-012 SHALL have port busy  output  1  record in flight or FIFO non-empty.
REQ-013 SHALL have port overflow  output  1  sticky: one or more records dropped.
REQ-014 SHALL have port drop_count  output  8  dropped records, saturating at 255.

Function
REQ-015 SHALL push one record {pc, inst, ra, sp} when retire_valid=1 and enable=1 and the FIFO is not full.
REQ-016 SHALL drop a push when the FIFO is full, even if a pop occurs in the same cycle, and set overflow and increment drop_count, saturating at 0xFF.
REQ-017 SHALL ignore retire_valid when enable=0, with no FIFO, overflow or drop_count change.
REQ-018 SHALL pop the FIFO head into the record shifter when the record FSM is R_IDLE and the FIFO is non-empty.
REQ-019 SHALL use record FSM states R_IDLE -> R_SEND, on pop, and R_SEND -> R_IDLE after the last byte's stop bit; R_SEND may go directly to the next R_SEND record if the FIFO is non-empty.
REQ-020 SHALL send the record byte order as sync 0xA5, then pc, inst, ra, sp, each word least-significant byte first.
REQ-021 SHALL send each byte as one start bit (0), eight data bits LSB first and one stop bit (1), each bit lasting exactly CLKS_PER_BIT cycles, with no idle gap between bytes or records.
REQ-022 SHALL start driving the start bit low 2 cycles after an accepted push, when the FIFO is empty and the FSM is R_IDLE.
REQ-023 SHALL complete a record in progress after enable falls.
REQ-024 SHALL drive busy=0 only when the FSM is R_IDLE and the FIFO is empty.

Reset
REQ-025 SHALL asynchronously force txd=1, busy=0, overflow=0, drop_count=0, FSM R_IDLE, FIFO empty and bit counters 0.
REQ-026 SHALL abort a frame in progress on reset, with txd high in the same cycle reset asserts and no partial byte sent after release.

Configuration
REQ-027 SHALL, with TRACE_REGS_EN defined, send 17-byte records: sync, pc, inst, ra, sp.
REQ-028 SHALL, without TRACE_REGS_EN, send 9-byte records (sync, pc, inst), omit ra and sp from FIFO storage, and leave retire_ra and retire_sp as unused ports.

Structure
REQ-029 SHALL place the trace record struct, TRACE_SYNC=8'hA5 and the record byte-count constants in the shared package ad100_pkg.
REQ-030 SHALL place the byte serialiser (start/data/stop FSM, bit timer, ready/valid byte input) in sub-module uart_tx, instantiated once.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, TRACE_REGS_EN unless noted)
REQ-031 SHALL cover: reset held 5 cycles -> txd=1, busy=0, overflow=0, drop_count=0 throughout.
REQ-032 SHALL cover: one retire with pc=0x00000004, inst=0x00100093, ra=0x00000001, sp=0x00000000 -> bytes A5 04 00 00 00 93 00 10 00 01 00 00 00 00 00 00 00; start bit 2 cycles after the push; 680 cycles total; busy falls after the last stop bit.
REQ-033 SHALL cover: 6 back-to-back retires -> 5 records sent, overflow=1, drop_count=1.
REQ-034 SHALL cover: 300 retires while output is blocked by a full FIFO -> drop_count saturates at 0xFF.
REQ-035 SHALL cover: reset asserted during byte 5 -> txd=1 immediately; after release a new retire sends a clean record starting with A5.
REQ-036 SHALL cover: TRACE_REGS_EN undefined, one retire -> 9 bytes in 360 cycles; enable=0 retires -> no txd activity.
